// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI mode-0 responder with a byte register file
//
// Purpose:
//   Answers an ADXL362-style command protocol: 0x0A = write, 0x0B = read.
//   The command byte is followed by an address byte and then by data bytes.
//   The address auto-increments and wraps modulo NUM_REGS.
//   SPI pins are oversampled in the i_clock domain.
//   i_clock must run at least 8x the sclk frequency.
//   A local parallel port loads and reads the same registers.
//
// Optional feature (macro SPI_SLAVE_ID_REG_EN):
//   reg[0] always reads DEVICE_ID.
//   Writes to address 0 are discarded. The SPI write strobe still pulses.
//
// Ports:
//   i_clock          system clock
//   i_reset_n        asynchronous active-low reset
//   i_sclk           SPI clock, idles low
//   i_ss             slave select, active-low
//   i_mosi           master-out data, MSB first
//   o_miso           slave-out data
//   i_loc_we         local register write enable
//   i_loc_addr       local write/read address
//   i_loc_wdata      local write data
//   o_loc_rdata      combinational read of reg[i_loc_addr]
//   o_spi_wr_stb     one-cycle pulse when an SPI write commits
//   o_spi_wr_addr    address of the committed SPI write
//   o_spi_wr_data    data of the committed SPI write
//   o_busy           high while synchronized ss is low
module spi_slave_regs #(
  parameter int         NUM_REGS  = 16,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] DEVICE_ID = 8'hAD
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_sclk,
  input  logic              i_ss,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic              i_loc_we,
  input  logic [ADDR_W-1:0] i_loc_addr,
  input  logic [7:0]        i_loc_wdata,
  output logic [7:0]        o_loc_rdata,
  output logic              o_spi_wr_stb,
  output logic [ADDR_W-1:0] o_spi_wr_addr,
  output logic [7:0]        o_spi_wr_data,
  output logic              o_busy
);

`ifdef SPI_SLAVE_ID_REG_EN
  localparam bit ID_REG_EN = 1'b1;
`else
  localparam bit ID_REG_EN = 1'b0;
`endif

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR,
    S_RD,
    S_IGNORE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic              r_ss_meta, r_ss_sync, r_ss_prev;
  logic              r_mosi_meta, r_mosi_sync;

  logic [2:0]        r_bitcnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_skip_fall;
  logic              r_rd_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mem [NUM_REGS];

  logic              r_wr_stb;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic              w_active;
  logic              w_rise;
  logic              w_fall;
  logic              w_ss_fall;
  logic              w_ss_rise;
  logic              w_shift_en;
  logic              w_byte_done;
  logic [7:0]        w_rx_next;
  logic              w_spi_commit;
  logic              w_tx_load;
  logic [ADDR_W-1:0] w_tx_addr;
  logic [7:0]        w_tx_src;

  // Two-flop synchronizers plus one history flop for edge detection.
  // Pin to event takes three clocks.
  // ss resets high so that busy reads 0 out of reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_ss_meta   <= 1'b1;
      r_ss_sync   <= 1'b1;
      r_ss_prev   <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_ss_meta   <= i_ss;
      r_ss_sync   <= r_ss_meta;
      r_ss_prev   <= r_ss_sync;
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // sclk edges only count while the synchronized select is low.
  assign w_active    = ~r_ss_sync;
  assign w_rise      = w_active & r_sclk_sync & ~r_sclk_prev;
  assign w_fall      = w_active & ~r_sclk_sync & r_sclk_prev;
  assign w_ss_fall   = ~r_ss_sync & r_ss_prev;
  assign w_ss_rise   = r_ss_sync & ~r_ss_prev;

  assign w_rx_next   = {r_rx[6:0], r_mosi_sync};
  assign w_shift_en  = w_rise && (r_state != S_IDLE);
  assign w_byte_done = w_shift_en && (r_bitcnt == 3'd7);

  // The tx snapshot comes from the same register view the local port reads.
  assign w_tx_src    = (ID_REG_EN && (w_tx_addr == '0)) ? DEVICE_ID : r_mem[w_tx_addr];
  assign o_loc_rdata = (ID_REG_EN && (i_loc_addr == '0)) ? DEVICE_ID : r_mem[i_loc_addr];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_spi_commit = 1'b0;
    w_tx_load    = 1'b0;
    w_tx_addr    = r_addr + ADDR_W'(1);
    if (w_ss_rise) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ss_fall) w_state_next = S_CMD;
        end
        S_CMD: begin
          if (w_byte_done) begin
            if ((w_rx_next == CMD_WRITE) || (w_rx_next == CMD_READ)) w_state_next = S_ADDR;
            else w_state_next = S_IGNORE;
          end
        end
        S_ADDR: begin
          if (w_byte_done) begin
            w_state_next = r_rd_mode ? S_RD : S_WR;
            w_tx_load    = r_rd_mode;
            w_tx_addr    = w_rx_next[ADDR_W-1:0];
          end
        end
        S_WR: begin
          w_spi_commit = w_byte_done;
        end
        S_RD: begin
          w_tx_load = w_byte_done;
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bitcnt    <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_skip_fall <= 1'b0;
      r_rd_mode   <= 1'b0;
      r_addr      <= '0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_stb <= 1'b0;

      if (w_ss_fall && (r_state == S_IDLE)) begin
        r_bitcnt <= '0;
        r_rx     <= '0;
      end else if (w_ss_rise) begin
        r_bitcnt <= '0;
      end else if (w_shift_en) begin
        r_rx     <= w_rx_next;
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if ((r_state == S_CMD) && w_byte_done) begin
        r_rd_mode <= (w_rx_next == CMD_READ);
      end

      if ((r_state == S_ADDR) && w_byte_done) begin
        r_addr <= w_rx_next[ADDR_W-1:0];
      end else if (((r_state == S_WR) || (r_state == S_RD)) && w_byte_done) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_spi_commit) begin
        r_wr_stb  <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= w_rx_next;
      end

      // The fall right after a load leaves tx alone.
      // That keeps the freshly loaded MSB on miso for the master's next rising edge.
      if (w_tx_load) begin
        r_tx        <= w_tx_src;
        r_skip_fall <= 1'b1;
      end else if ((r_state == S_RD) && w_fall) begin
        if (r_skip_fall) r_skip_fall <= 1'b0;
        else             r_tx        <= {r_tx[6:0], 1'b0};
      end
    end
  end

  // On a same-cycle collision at one address, the SPI commit wins over the local write.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!(ID_REG_EN && (i == 0))) begin
          if (w_spi_commit && (r_addr == ADDR_W'(i))) begin
            r_mem[i] <= w_rx_next;
          end else if (i_loc_we && (i_loc_addr == ADDR_W'(i))) begin
            r_mem[i] <= i_loc_wdata;
          end
        end
      end
    end
  end

  assign o_miso        = (r_state == S_RD) & r_tx[7];
  assign o_busy        = ~r_ss_sync;
  assign o_spi_wr_stb  = r_wr_stb;
  assign o_spi_wr_addr = r_wr_addr;
  assign o_spi_wr_data = r_wr_data;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - scoreboard bench for spi_slave_regs
module tb_spi_slave_regs;
  localparam int NR = 16;
  localparam int AW = 4;

`ifdef SPI_SLAVE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          ss = 1'b1;
  logic          mosi = 1'b0;
  logic          loc_we = 1'b0;
  logic [AW-1:0] loc_addr = '0;
  logic [7:0]    loc_wdata = '0;
  logic          miso, wr_stb, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, loc_rdata;

  spi_slave_regs #(.NUM_REGS(NR), .ADDR_W(AW), .DEVICE_ID(8'hAD)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_sclk(sclk), .i_ss(ss), .i_mosi(mosi),
    .o_miso(miso), .i_loc_we(loc_we), .i_loc_addr(loc_addr), .i_loc_wdata(loc_wdata),
    .o_loc_rdata(loc_rdata), .o_spi_wr_stb(wr_stb), .o_spi_wr_addr(wr_addr),
    .o_spi_wr_data(wr_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    mem [NR];
  wr_t           exp_wr[$];
  logic [7:0]    exp_rd[$];
  logic [7:0]    rd_obs;
  event          rd_ev;
  logic [AW-1:0] inj_addr = '0;
  logic [7:0]    inj_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
    return (ID_EN && a == 0) ? 8'hAD : mem[a];
  endfunction

  task automatic model_wr(input logic [AW-1:0] a, input logic [7:0] d);
    if (!(ID_EN && a == 0)) mem[a] = d;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wr_stb) begin
      if (exp_wr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_stb: unexpected strobe addr %0h data %0h", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  always begin
    @(rd_ev);
    if (exp_rd.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL miso_byte: unexpected byte %0h", rd_obs);
    end else begin
      check("miso_byte", 32'(rd_obs), 32'(exp_rd.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One SPI byte, mode 0.
  // Half period is 4 clocks. miso is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit inj, input bit chk);
    logic [7:0] rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      if (inj && i == nbits - 1) begin
        // The local write lands on the same clock as the SPI commit.
        repeat (2) @(negedge clk);
        loc_addr = inj_addr;
        loc_wdata = inj_data;
        loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
    if (chk) begin
      rd_obs = rx;
      ->rd_ev;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (6) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_write(input logic [7:0] a, input int n, input logic [31:0] bytes, input int inj);
    logic [AW-1:0] ai = a[AW-1:0];
    logic [7:0] d;
    spi_begin();
    xfer(8'h0A, 8, 1'b0, 1'b0);
    xfer(a, 8, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = bytes[31-8*i -: 8];
      exp_wr.push_back('{a: ai, d: d});
      model_wr(ai, d);
      xfer(d, 8, (i == inj), 1'b0);
      ai = ai + 1'b1;
    end
    spi_end();
  endtask

  task automatic spi_read(input logic [7:0] a, input int n);
    logic [AW-1:0] ai = a[AW-1:0];
    spi_begin();
    xfer(8'h0B, 8, 1'b0, 1'b0);
    xfer(a, 8, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(model_rd(ai));
      xfer(8'(i * 37), 8, 1'b0, 1'b1);
      ai = ai + 1'b1;
    end
    spi_end();
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a;
    loc_wdata = d;
    loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    model_wr(a, d);
  endtask

  task automatic check_loc(input logic [AW-1:0] a);
    @(negedge clk);
    loc_addr = a;
    #1;
    check($sformatf("loc_rdata[%0d]", a), 32'(loc_rdata), 32'(model_rd(a)));
  endtask

  initial begin
    logic [7:0] ra;
    int op, n;
    for (int i = 0; i < NR; i++) mem[i] = '0;

    // Reset with random pin activity.
    rst_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      sclk = 1'($urandom);
      ss = 1'($urandom);
      mosi = 1'($urandom);
      loc_we = 1'($urandom);
      loc_wdata = 8'($urandom);
      loc_addr = AW'($urandom);
    end
    #1;
    check("rst_miso", 32'(miso), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr_stb", 32'(wr_stb), 32'(0));
    loc_we = 1'b0;
    for (int a = 0; a < NR; a++) check_loc(AW'(a));
    @(negedge clk);
    sclk = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write burst.
    spi_write(8'h03, 2, 32'h5AC3_0000, -1);
    check_loc(AW'(3));
    check_loc(AW'(4));

    // Read wrapping from 15 to 0.
    loc_write(AW'(15), 8'h11);
    loc_write(AW'(0), 8'h22);
    spi_read(8'h0F, 2);

    // An unknown command must never drive miso and must never write.
    spi_begin();
    for (int i = 0; i < 3; i++) begin
      exp_rd.push_back(8'h00);
      xfer((i == 0) ? 8'h07 : (i == 1) ? 8'h02 : 8'hFF, 8, 1'b0, 1'b1);
    end
    check("ignore_busy", 32'(busy), 32'(1));
    spi_end();

    // A partial data byte is dropped when ss rises.
    loc_write(AW'(2), 8'h6E);
    spi_begin();
    xfer(8'h0A, 8, 1'b0, 1'b0);
    xfer(8'h02, 8, 1'b0, 1'b0);
    xfer(8'hF0, 4, 1'b0, 1'b0);
    spi_end();
    check_loc(AW'(2));
    check("idle_busy", 32'(busy), 32'(0));

    // Collision: SPI commit to 5 and a local write to 5 on the same clock.
    inj_addr = AW'(5);
    inj_data = 8'h44;
    spi_write(8'h05, 1, 32'h9900_0000, 0);
    check_loc(AW'(5));

    // Address 0 write. It is discarded when the ID register is enabled.
    spi_write(8'h00, 1, 32'h1200_0000, -1);
    check_loc(AW'(0));
    loc_write(AW'(0), 8'h77);
    check_loc(AW'(0));

    // Randomized traffic.
    repeat (14) begin
      op = $urandom_range(0, 2);
      ra = 8'($urandom);
      if (op == 0) begin
        n = $urandom_range(1, 4);
        spi_write(ra, n, $urandom, -1);
      end else if (op == 1) begin
        n = $urandom_range(1, 3);
        spi_read(ra, n);
      end else begin
        loc_write(ra[AW-1:0], 8'($urandom));
      end
    end
    for (int a = 0; a < NR; a++) check_loc(AW'(a));
    spi_read(8'h00, NR + 1);

    repeat (10) @(negedge clk);
    check("pending_writes", 32'(exp_wr.size()), 32'(0));
    check("pending_reads", 32'(exp_rd.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI mode-0 responder with a small byte register file, using an ADXL362-style command protocol (0x0A write, 0x0B read, then address, then auto-incrementing data).
- It is the other end of the Wrapper's SPI master link (sclk/mosi/miso/ss). It serves as an accelerometer stand-in for simulation, and as an SPI peripheral when a second board drives the link.
- Local logic (game/VGA side) loads and reads registers through a parallel port.
- SPI pins are oversampled in the system clock domain.

Parameters:
- NUM_REGS, 16: number of 8-bit registers. Power of two, 2..256.
- ADDR_W, 4: local address width, equal to log2(NUM_REGS).
- DEVICE_ID, 8'hAD: fixed value of register 0 when SPI_SLAVE_ID_REG_EN is defined.

Ports:
- clock  in  1  system clock; must be at least 8x sclk frequency.
- reset  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock from master; idles low (mode 0).
- ss  in  1  slave select, active-low.
- mosi  in  1  master-out data, MSB first.
- miso  out  1  slave-out data.
- loc_we  in  1  local register write enable.
- loc_addr  in  ADDR_W  local write/read address.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  combinational read of reg[loc_addr].
- spi_wr_stb  out  1  one-cycle pulse when an SPI write commits.
- spi_wr_addr  out  ADDR_W  address of the committed SPI write.
- spi_wr_data  out  8  data of the committed SPI write.
- busy  out  1  high while ss is low (synchronized).

Behaviour:
- Synchronization: sclk, ss and mosi each pass through a 2-FF synchronizer. Edge detect on the synchronized sclk gives rise_p and fall_p. The ss falling/rising edge is detected likewise. Internal latency is 3 clocks from pin to event.
- Reset (reset=0, async): all registers 0, except reg[0] per the optional feature. FSM goes to IDLE. Bit count 0. miso=0, spi_wr_stb=0, spi_wr_addr=0, spi_wr_data=0, busy=0.
- FSM states: IDLE, CMD, ADDR, WR, RD, IGNORE.
  - IDLE: on synchronized ss falling go to CMD, clear bit count and shift register.
  - Each rise_p shifts synchronized mosi into the 8-bit rx shift register (LSB in) and increments a 3-bit bit count. Byte complete = the 8th rise_p; bit count wraps to 0.
  - CMD, byte complete: 0x0A -> ADDR (write mode); 0x0B -> ADDR (read mode); any other value -> IGNORE.
  - ADDR, byte complete: latch the address as rx[ADDR_W-1:0] (upper bits discarded), then go to WR or RD.
    - Read mode: in the same cycle, load the tx shift register with reg[addr] and drive miso = tx[7] immediately.
  - WR, byte complete:
    - reg[addr] <= rx.
    - spi_wr_stb=1 for exactly one clock, with spi_wr_addr=addr and spi_wr_data=rx.
    - addr <= addr+1, wrapping modulo NUM_REGS.
  - RD:
    - On each fall_p, tx shifts left and miso = new tx[7].
    - On byte complete, addr <= addr+1 (wraps); tx reloads from reg[addr+1]; miso = its MSB.
    - The fall_p following a reload does not shift.
  - IGNORE: miso=0 and no register effect until ss rises.
  - Any state: synchronized ss rising -> IDLE, miso=0, bit count cleared. A partial byte is discarded with no write.
- busy equals synchronized ss inverted.
- Collisions:
  - Local write and SPI commit to the same address in the same clock: SPI data wins. The local write is dropped and no error is flagged.
  - Local write to another address proceeds normally.
- A local write during an SPI read affects only bytes not yet loaded into tx.
- Read data is a snapshot taken at the tx load instant.
- loc_rdata is combinational and reflects writes one clock after commit.
- mosi is ignored while ss is high. sclk edges while ss is high are ignored.
- Reset asserted mid-transaction: immediate return to the reset state. An interrupted write does not commit.

Optional Feature:
- Macro: SPI_SLAVE_ID_REG_EN.
- Defined:
  - reg[0] reads DEVICE_ID at all times, including after reset.
  - SPI and local writes to address 0 are discarded. spi_wr_stb still pulses for an SPI write there, with the attempted data.
  - Auto-increment behaves normally.
- Undefined: reg[0] is an ordinary register with reset value 0.

Test Plan:
- Reset: hold reset=0 with random pins -> miso=0, busy=0, spi_wr_stb=0, loc_rdata=0 at every address (reg[0]=0xAD with the macro defined).
- SPI write burst: sclk=clock/8, ss low, send 0x0A,0x03,0x5A,0xC3, ss high -> spi_wr_stb pulses twice: (3,0x5A) then (4,0xC3); loc_rdata at 3 = 0x5A, at 4 = 0xC3.
- SPI read with wrap: local-write reg[15]=0x11 and reg[0]=0x22 (no macro); send 0x0B,0x0F then 16 clocks -> master samples 0x11 then 0x22 on sclk rising edges.
- Bad command and abort: send 0x07,0x02,0xFF -> no spi_wr_stb and miso=0 throughout. Then send 0x0A,0x02,0xF (4 bits), raise ss -> reg[2] unchanged.
- Collision: spi_wr_stb commit to address 5 with 0x99, coincident with loc_we to address 5 with 0x44 -> reg[5]=0x99.
- Macro defined: write 0x0A,0x00,0x12 -> spi_wr_stb pulse with data 0x12; read back at address 0 = 0xAD.
